// File: rtl/sdram_write.sv
// SDRAM write-burst command generator: ACTIVE, full-page WRITE streamed from a
// show-ahead FIFO, BURST STOP, PRECHARGE ALL, then a one-cycle wr_end pulse.
module sdram_write #(
  parameter int unsigned TRCD_CLK = 2,
  parameter int unsigned TWR_CLK  = 2,
  parameter int unsigned TRP_CLK  = 2
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        init_end,
  input  logic        wr_en,
  input  logic [23:0] wr_addr_in,
  input  logic [9:0]  wr_burst_len,
  input  logic [15:0] wr_data_in,
  output logic        wr_ack,
  output logic        wr_end,
  output logic [3:0]  wr_sdram_cmd,
  output logic [1:0]  wr_sdram_ba,
  output logic [12:0] wr_sdram_addr,
  output logic        wr_sdram_en,
  output logic [15:0] wr_sdram_data
);

  localparam int unsigned CW = 10;
  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_BSTOP = 4'b0110;
  localparam logic [3:0] CMD_PRE   = 4'b0010;

  typedef enum logic [3:0] {
    S_IDLE, S_ACTIVE, S_TRCD, S_WRITE, S_DATA, S_BSTOP, S_PRE, S_TRP, S_END
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] len_q;
  logic [CW-1:0] len_d;
  logic [23:0]   addr_q;

  // Burst length of 0 means one word; a full page is 512 words at most.
  always_comb begin
    len_d = wr_burst_len;
    if (wr_burst_len == '0) begin
      len_d = CW'(1);
    end else if (wr_burst_len > CW'(512)) begin
      len_d = CW'(512);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      addr_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (init_end && wr_en) begin
            state_q <= S_ACTIVE;
            addr_q  <= wr_addr_in;
            len_q   <= len_d;
          end
        end
        S_ACTIVE: begin
          state_q <= S_TRCD;
          cnt_q   <= '0;
        end
        S_TRCD: begin
          if (cnt_q == CW'(TRCD_CLK - 1)) begin
            state_q <= S_WRITE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_WRITE: begin
          // cnt_q tracks the index of the word being driven in DATA
          if (len_q == CW'(1)) begin
            state_q <= S_BSTOP;
            cnt_q   <= '0;
          end else begin
            state_q <= S_DATA;
            cnt_q   <= CW'(1);
          end
        end
        S_DATA: begin
          if (cnt_q == len_q - CW'(1)) begin
            state_q <= S_BSTOP;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_BSTOP: begin
          if (cnt_q == CW'(TWR_CLK - 1)) begin
            state_q <= S_PRE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_PRE: begin
          state_q <= S_TRP;
          cnt_q   <= '0;
        end
        S_TRP: begin
          if (cnt_q == CW'(TRP_CLK - 1)) begin
            state_q <= S_END;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_END: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Command/address decode; PRECHARGE ALL relies on the all-ones default (A10=1).
  always_comb begin
    wr_sdram_cmd  = CMD_NOP;
    wr_sdram_ba   = 2'b11;
    wr_sdram_addr = 13'h1fff;
    wr_ack        = 1'b0;
    wr_end        = 1'b0;
    case (state_q)
      S_ACTIVE: begin
        wr_sdram_cmd  = CMD_ACT;
        wr_sdram_ba   = addr_q[23:22];
        wr_sdram_addr = addr_q[21:9];
      end
      S_WRITE: begin
        wr_sdram_cmd  = CMD_WRITE;
        wr_sdram_ba   = addr_q[23:22];
        wr_sdram_addr = {4'b0000, addr_q[8:0]};
        wr_ack        = 1'b1;
      end
      S_DATA:  wr_ack = 1'b1;
      S_BSTOP: begin
        if (cnt_q == '0) begin
          wr_sdram_cmd = CMD_BSTOP;
        end
      end
      S_PRE:   wr_sdram_cmd = CMD_PRE;
      S_END:   wr_end = 1'b1;
      default: ;
    endcase
  end

  assign wr_sdram_en   = wr_ack;
  assign wr_sdram_data = wr_ack ? wr_data_in : 16'h0000;

endmodule

// File: tb/tb_sdram_write.sv
// Scoreboarded bench for sdram_write: stimulus queues expected command/data
// events with cycle offsets from ACTIVE; a monitor pops one per DUT event.
module tb_sdram_write;

  localparam logic [3:0] NOP   = 4'b0111;
  localparam logic [3:0] ACT   = 4'b0011;
  localparam logic [3:0] WRT   = 4'b0100;
  localparam logic [3:0] BSTOP = 4'b0110;
  localparam logic [3:0] PRE   = 4'b0010;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        init_end;
  logic        wr_en;
  logic [23:0] wr_addr_in;
  logic [9:0]  wr_burst_len;
  logic [15:0] wr_data_in;
  logic        wr_ack;
  logic        wr_end;
  logic [3:0]  wr_sdram_cmd;
  logic [1:0]  wr_sdram_ba;
  logic [12:0] wr_sdram_addr;
  logic        wr_sdram_en;
  logic [15:0] wr_sdram_data;

  typedef struct {
    int          ofs;
    logic [3:0]  cmd;
    logic [1:0]  ba;
    logic [12:0] addr;
    logic        ack;
    logic [15:0] data;
    logic        fin;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  exp_words = 0;
  int  fifo_pops = 0;

  sdram_write dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .init_end      (init_end),
    .wr_en         (wr_en),
    .wr_addr_in    (wr_addr_in),
    .wr_burst_len  (wr_burst_len),
    .wr_data_in    (wr_data_in),
    .wr_ack        (wr_ack),
    .wr_end        (wr_end),
    .wr_sdram_cmd  (wr_sdram_cmd),
    .wr_sdram_ba   (wr_sdram_ba),
    .wr_sdram_addr (wr_sdram_addr),
    .wr_sdram_en   (wr_sdram_en),
    .wr_sdram_data (wr_sdram_data)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic [15:0] fword(input int i);
    return 16'(i * 263 + 15360);
  endfunction

  // Show-ahead FIFO model: head word changes after each acknowledged pop.
  always @(posedge sys_clk) if (wr_ack === 1'b1) fifo_pops <= fifo_pops + 1;
  always_comb wr_data_in = fword(fifo_pops);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic chk_idle(input string nm);
    chk(nm, 64'({wr_sdram_cmd, wr_sdram_ba, wr_sdram_addr, wr_ack, wr_end, wr_sdram_en, wr_sdram_data}),
        64'({NOP, 2'b11, 13'h1fff, 1'b0, 1'b0, 1'b0, 16'h0000}));
  endtask

  task automatic push_ev(input int ofs, input logic [3:0] cmd, input logic [1:0] ba,
                         input logic [12:0] addr, input logic ack, input logic [15:0] data,
                         input logic fin);
    ev_t e;
    e.ofs = ofs; e.cmd = cmd; e.ba = ba; e.addr = addr; e.ack = ack; e.data = data; e.fin = fin;
    exp_q.push_back(e);
  endtask

  // Offsets for TRCD=TWR=TRP=2: WRITE at 3, BSTOP at 3+len, PRE at 5+len, END at 8+len.
  task automatic push_burst(input logic [1:0] ba, input logic [12:0] row, input logic [8:0] col,
                            input int len, input bit full, input int nwords);
    push_ev(0, ACT, ba, row, 1'b0, 16'h0, 1'b0);
    for (int k = 0; k < nwords; k++) begin
      if (k == 0) push_ev(3, WRT, ba, {4'b0000, col}, 1'b1, fword(exp_words), 1'b0);
      else        push_ev(3 + k, NOP, 2'b11, 13'h1fff, 1'b1, fword(exp_words), 1'b0);
      exp_words++;
    end
    if (full) begin
      push_ev(3 + len, BSTOP, 2'b11, 13'h1fff, 1'b0, 16'h0, 1'b0);
      push_ev(5 + len, PRE,   2'b11, 13'h1fff, 1'b0, 16'h0, 1'b0);
      push_ev(8 + len, NOP,   2'b11, 13'h1fff, 1'b0, 16'h0, 1'b1);
    end
  endtask

  task automatic monitor();
    int  cyc = 0;
    int  base = 0;
    int  nev = 0;
    ev_t e;
    forever begin
      @(negedge sys_clk);
      cyc++;
      if (wr_sdram_cmd !== NOP || wr_ack === 1'b1 || wr_end === 1'b1) begin
        if (wr_sdram_cmd === ACT) base = cyc;
        nev++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event%0d: actual cmd=%b ack=%b end=%b, required no event",
                   nev, wr_sdram_cmd, wr_ack, wr_end);
        end else begin
          e = exp_q.pop_front();
          if ((cyc - base) != e.ofs || wr_sdram_cmd !== e.cmd || wr_sdram_ba !== e.ba ||
              wr_sdram_addr !== e.addr || wr_ack !== e.ack || wr_sdram_en !== e.ack ||
              wr_sdram_data !== e.data || wr_end !== e.fin) begin
            errors++;
            $display("FAIL event%0d: actual ofs=%0d cmd=%b ba=%0d addr=%h ack=%b en=%b data=%h end=%b, required ofs=%0d cmd=%b ba=%0d addr=%h ack=%b data=%h end=%b",
                     nev, cyc - base, wr_sdram_cmd, wr_sdram_ba, wr_sdram_addr, wr_ack, wr_sdram_en,
                     wr_sdram_data, wr_end, e.ofs, e.cmd, e.ba, e.addr, e.ack, e.data, e.fin);
          end
        end
      end
    end
  endtask

  task automatic wait_end(input int elen);
    int acks = 0;
    bit seen = 1'b0;
    int c = 0;
    while (c < elen + 40 && !seen) begin
      @(posedge sys_clk); #1;
      if (wr_ack === 1'b1) acks++;
      if (wr_end === 1'b1) seen = 1'b1;
      c++;
    end
    chk("wr_end_seen", 64'(seen), 64'(1));
    chk("ack_count", 64'(acks), 64'(elen));
    @(posedge sys_clk); #1;
    wr_en = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic run_burst(input logic [23:0] a, input logic [9:0] len_in, input logic [1:0] eba,
                           input logic [12:0] erow, input logic [8:0] ecol, input int elen);
    push_burst(eba, erow, ecol, elen, 1'b1, elen);
    wr_addr_in   = a;
    wr_burst_len = len_in;
    wr_en        = 1'b1;
    wait_end(elen);
  endtask

  initial begin
    int n;
    sys_rst      = 1'b1;
    init_end     = 1'b0;
    wr_en        = 1'b0;
    wr_addr_in   = '0;
    wr_burst_len = '0;
    fork
      monitor();
    join_none
    repeat (3) @(posedge sys_clk);
    #1;
    chk_idle("reset_state");
    sys_rst  = 1'b0;
    init_end = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge sys_clk); #1;
      chk_idle("idle_no_grant");
    end

    run_burst(24'h400A05, 10'd10, 2'd1, 13'h0005, 9'h005, 10);
    run_burst(24'hF57800, 10'd1,  2'd3, 13'h1ABC, 9'h000, 1);
    run_burst(24'h0003FF, 10'd0,  2'd0, 13'h0001, 9'h1FF, 1);
    run_burst(24'h8247F0, 10'd700, 2'd2, 13'h0123, 9'h1F0, 512);

    // init_end low must block the grant
    init_end = 1'b0;
    push_burst(2'd2, 13'h0FFF, 9'h0AA, 3, 1'b1, 3);
    wr_addr_in   = 24'h9FFEAA;
    wr_burst_len = 10'd3;
    wr_en        = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge sys_clk); #1;
      chk("init_blocks", 64'(wr_sdram_cmd), 64'(NOP));
    end
    init_end = 1'b1;
    chk("init_rise_nop", 64'(wr_sdram_cmd), 64'(NOP));
    @(posedge sys_clk); #1;
    chk("active_after_init", 64'(wr_sdram_cmd), 64'(ACT));
    wait_end(3);

    // Reset during the fifth word abandons the burst
    push_burst(2'd1, 13'h0010, 9'h020, 8, 1'b0, 5);
    wr_addr_in   = 24'h402020;
    wr_burst_len = 10'd8;
    wr_en        = 1'b1;
    n = 0;
    for (int c = 0; c < 40 && n < 5; c++) begin
      @(posedge sys_clk); #1;
      if (wr_ack === 1'b1) n++;
    end
    chk("abort_word5_reached", 64'(n), 64'(5));
    sys_rst = 1'b1;
    @(posedge sys_clk); #1;
    chk_idle("rst_mid_burst_idle");
    sys_rst = 1'b0;
    push_burst(2'd1, 13'h0010, 9'h020, 8, 1'b1, 8);
    @(posedge sys_clk); #1;
    chk("fresh_active", 64'({wr_sdram_cmd, wr_sdram_ba, wr_sdram_addr}), 64'({ACT, 2'd1, 13'h0010}));
    wait_end(8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
